pkt_prior_dequeuer: RTL

Consumer end of the priority-tagging stage. It accepts the (valid, data, prior) stream produced by the packet priority calculator and buffers up to QUEUE_SIZE entries. It presents the most urgent entry to the egress side with a show-ahead dequeue interface. Among entries of equal priority it serves the oldest first, and an anti-starvation counter guarantees the oldest entry is eventually served.

---
 rtl/pkt_prior_dequeuer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pkt_prior_dequeuer.sv
// Priority dequeuer: age-ordered compacting buffer with show-ahead egress.
// Index 0 is always the oldest entry; valid entries sit in 0..count-1.
// The most urgent entry (ties -> oldest) is presented, unless the oldest
// entry has been bypassed STARVE_LIMIT times, in which case it is forced out.

// One storage slot: loads a new entry, or takes its upper neighbour on compaction.
module pkt_prior_slot #(
  parameter int EW = 38
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          shift,
  input  logic          load,
  input  logic [EW-1:0] up_ent,
  input  logic [EW-1:0] in_ent,
  output logic [EW-1:0] ent
);

  // Load wins over shift: an enqueue lands on the slot freed by compaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       ent <= '0;
    else if (load)  ent <= in_ent;
    else if (shift) ent <= up_ent;
  end

endmodule

module pkt_prior_dequeuer #(
  parameter int DWIDTH       = 32,
  parameter int PRIOR_WIDTH  = 6,
  parameter int QUEUE_SIZE   = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DWIDTH-1:0]             in_data,
  input  logic [PRIOR_WIDTH-1:0]        in_prior,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [DWIDTH-1:0]             out_data,
  output logic [PRIOR_WIDTH-1:0]        out_prior,
  input  logic                          out_deq_en,
  output logic [$clog2(QUEUE_SIZE):0]   count,
  output logic [15:0]                   drop_cnt
);

  localparam int IW = $clog2(QUEUE_SIZE);
  localparam int CW = IW + 1;
  localparam int EW = DWIDTH + PRIOR_WIDTH;
  localparam logic [7:0] SLIM = 8'(STARVE_LIMIT);

  // Slot contents, packed as {data, prior}.
  logic [QUEUE_SIZE-1:0][EW-1:0] ent;
  logic [QUEUE_SIZE-1:0][EW-1:0] up_ent;
  logic [QUEUE_SIZE-1:0]         shift;
  logic [QUEUE_SIZE-1:0]         load;

  logic [IW-1:0]          sel;
  logic [PRIOR_WIDTH-1:0] best;
  logic                   do_push;
  logic                   do_pop;
  logic [CW-1:0]          wr_idx;
  logic [CW-1:0]          count_n;
  logic [7:0]             byp_cnt;
  logic [7:0]             byp_n;

  assign in_ready  = (count != CW'(QUEUE_SIZE));
  assign out_valid = (count != '0);
  assign do_push   = in_valid && in_ready;
  assign do_pop    = out_deq_en && out_valid;
  // With a pop in the same cycle the tail moves down by one.
  assign wr_idx    = count - CW'(do_pop);
  assign count_n   = count + CW'(do_push) - CW'(do_pop);

  // Pick the forced oldest entry when starving, else the highest priority (oldest on tie).
  always_comb begin
    sel  = '0;
    best = '0;
    if (STARVE_LIMIT != 0 && byp_cnt == SLIM) begin
      sel = '0;
    end else begin
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        if (CW'(i) < count && ent[i][PRIOR_WIDTH-1:0] > best) begin
          best = ent[i][PRIOR_WIDTH-1:0];
          sel  = IW'(i);
        end
      end
    end
  end

  assign out_data  = out_valid ? ent[sel][EW-1:PRIOR_WIDTH] : '0;
  assign out_prior = out_valid ? ent[sel][PRIOR_WIDTH-1:0]  : '0;

  // Per-slot control: everything at or above the popped index shifts down.
  for (genvar i = 0; i < QUEUE_SIZE; i++) begin : g_slot
    if (i < QUEUE_SIZE - 1) begin : g_up
      assign up_ent[i] = ent[i+1];
    end else begin : g_top
      assign up_ent[i] = '0;
    end
    assign shift[i] = do_pop  && (CW'(i) >= {1'b0, sel});
    assign load[i]  = do_push && (wr_idx == CW'(i));

    pkt_prior_slot #(.EW(EW)) u_slot (
      .clk    (clk),
      .rst    (rst),
      .shift  (shift[i]),
      .load   (load[i]),
      .up_ent (up_ent[i]),
      .in_ent ({in_data, in_prior}),
      .ent    (ent[i])
    );
  end

  // Bypass counter: reset by serving the oldest, bumped (saturating) by serving any other.
  always_comb begin
    byp_n = byp_cnt;
    if (do_pop) begin
      if (sel == '0)           byp_n = '0;
      else if (byp_cnt < SLIM) byp_n = byp_cnt + 8'd1;
    end
    if (count_n == '0) byp_n = '0;
  end

  // Occupancy, bypass and drop bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      byp_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      count   <= count_n;
      byp_cnt <= byp_n;
      if (in_valid && !in_ready && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule
